ieee1355_rx_char_decoder: RTL and testbench
===========================================

// Module: ieee1355_rx_char_decoder
// PURPOSE
//  Character-level receive decoder sitting directly downstream of the DS bit-recovery front end.
//  Consumes the recovered serial bit stream and aligns on the first NULL.
//  Decodes data, EOP_1/EOP_2, FCC(FCT) and ESC characters and checks odd/even link parity.
//  Data/EOP tokens feed the RX FIFO write port; NULL/FCT pulses and errors feed the link state machine.
// PARAMETERS
//  G_LINK_PARITY_IS_ODD  1    1: link parity odd; 0: even
//  G_DISC_TIMEOUT_CLKS   64   clk cycles with no rx_bit_valid while aligned before disconnect error
// PORTS
//  clk           in   1  system clock; all logic rising-edge
//  rst           in   1  synchronous, active-high reset
//  rx_bit        in   1  recovered bit (D sample), first-transmitted bit first
//  rx_bit_valid  in   1  rx_bit qualifier, one cycle per bit
//  tok_valid     out  1  one-cycle pulse: token on tok_is_ctrl/tok_data
//  tok_is_ctrl   out  1  0: data byte; 1: EOP, code in tok_data[1:0]
//  tok_data      out  8  data byte, or {6'b0,c1,c0} (EOP_1=2'b10, EOP_2=2'b01)
//  aligned       out  1  high from first NULL until error or reset
//  null_seen     out  1  one-cycle pulse per NULL (ESC+FCC) received
//  fct_seen      out  1  one-cycle pulse per standalone FCC received
//  err_parity    out  1  one-cycle pulse on parity failure
//  err_esc       out  1  one-cycle pulse: ESC followed by non-FCC control or data
//  err_disc      out  1  one-cycle pulse: disconnect timeout
// BEHAVIOUR
//  - Rules apply only on cycles with rx_bit_valid=1 unless stated. Reset: state=HUNT; all outputs 0; accumulators cleared.
//  - Character on wire: P, F, then payload: 8 data bits LSB first (F=0) or 2 code bits c0,c1 (F=1).
//    FCC=00, EOP_2: c0=1,c1=0, EOP_1: c0=0,c1=1, ESC=11 (c0,c1).
//  - Parity: XOR(previous char payload bits, P, F) == G_LINK_PARITY_IS_ODD; checked on F bit.
//  - HUNT: 7-bit shift register; match time-ordered 1,1,1,Q,1,0,0 (Q = ~G_LINK_PARITY_IS_ODD)
//    -> aligned<=1, null_seen pulse, parity accumulator seeded with FCC payload (0), go PAR.
//  - PAR: capture P -> FLAG.
//  - FLAG: parity check. Fail: err_parity, aligned<=0, esc_pend<=0, go HUNT. Pass: load count 2 (F=1) or 8 (F=0) -> PAYLOAD.
//  - PAYLOAD: shift bits, fold into next-char parity accumulator. On last bit, decode; go PAR.
//    data: tok_valid, tok_is_ctrl=0.
//    ESC: set esc_pend, no output.
//    FCC: null_seen if esc_pend (clear it), else fct_seen.
//    EOP: tok_valid, tok_is_ctrl=1.
//    esc_pend set and char is not FCC: err_esc, no token, aligned<=0, go HUNT.
//  - Latency: all pulses registered; asserted the cycle after the valid cycle carrying the last payload bit (parity error: after F bit).
//  - Disconnect: counter clears on every rx_bit_valid and increments otherwise while aligned.
//    Reaching G_DISC_TIMEOUT_CLKS -> err_disc pulse, aligned<=0, HUNT. Counter inactive in HUNT.
//  - No back-pressure: consumer accepts every tok_valid. At most one token per 4 valid bits.
//  - Simultaneous: error pulses exclude tok_valid/null_seen/fct_seen in the same cycle.
//  - HUNT re-entry clears the shift register; the first 7 bits after re-entry cannot match.
//  - rst mid-character: abandon partial char, return to reset values next cycle.
// TESTING
//  - Odd link: stream 0,1,1,1,0,1,0,0 -> aligned=1 and null_seen pulse 1 clk after last bit; no tok_valid.
//  - After NULL: 1,0,1,0,1,0,0,1,0,1 -> tok_valid, tok_is_ctrl=0, tok_data=8'hA5.
//  - Then EOP_1: 0,1,0,1 -> tok_valid, tok_is_ctrl=1, tok_data=8'h02. Flip its P bit instead -> err_parity, aligned=0, no token.
//  - After NULL, lone FCC 1,1,0,0 -> fct_seen only. ESC then EOP_2 (0,1,1,1 then 0,1,1,0) -> err_esc, HUNT.
//  - Aligned, hold rx_bit_valid=0 for 64 clks -> err_disc on timeout cycle+1, aligned=0. 63 idle clks -> no error.
//  - Assert rst after 5 bits of a data char -> all outputs 0, HUNT. Re-send NULL -> realigns normally.
//  - Even link (G_LINK_PARITY_IS_ODD=0): 1,1,1,1,1,1,0,0 -> null_seen. The odd-link NULL pattern is ignored.

Source files
------------

// File: rtl/ieee1355_rx_char_decoder.sv
// ----------------------------------------------------------------------------
// ieee1355_rx_char_decoder
//
// Character-level receive decoder placed after the DS bit-recovery front end.
// It hunts for the first NULL (ESC followed by FCC) in the recovered bit
// stream. Once aligned, it frames each character as P, F, then the payload.
// The payload is 8 data bits LSB first when F=0, or 2 code bits c0,c1 when
// F=1. The decoder checks link parity, reports data/EOP tokens, reports
// NULL/FCT pulses, and reports protocol errors.
//
// Ports
//   clk           in   system clock, rising edge
//   rst           in   synchronous active-high reset
//   rx_bit        in   recovered bit, first-transmitted bit first
//   rx_bit_valid  in   one-cycle qualifier for rx_bit
//   tok_valid     out  one-cycle pulse: token on tok_is_ctrl/tok_data
//   tok_is_ctrl   out  0: data byte, 1: EOP with code in tok_data[1:0]
//   tok_data      out  data byte or {6'b0,c1,c0} (EOP_1=2'b10, EOP_2=2'b01)
//   aligned       out  high from first NULL until an error or reset
//   null_seen     out  one-cycle pulse per NULL
//   fct_seen      out  one-cycle pulse per standalone FCC
//   err_parity    out  one-cycle pulse on link parity failure
//   err_esc       out  one-cycle pulse: ESC followed by non-FCC
//   err_disc      out  one-cycle pulse: no rx_bit_valid for the timeout
// ----------------------------------------------------------------------------
module ieee1355_rx_char_decoder #(
    parameter bit G_LINK_PARITY_IS_ODD = 1'b1,
    parameter int G_DISC_TIMEOUT_CLKS  = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_bit,
    input  logic       rx_bit_valid,
    output logic       tok_valid,
    output logic       tok_is_ctrl,
    output logic [7:0] tok_data,
    output logic       aligned,
    output logic       null_seen,
    output logic       fct_seen,
    output logic       err_parity,
    output logic       err_esc,
    output logic       err_disc
);

    localparam int CW = $clog2(G_DISC_TIMEOUT_CLKS + 1);

    // NULL as seen while hunting: F,c0,c1 of ESC, then P,F,c0,c1 of FCC.
    // The FCC parity bit follows from the ESC payload (c0^c1 = 0).
    localparam logic       HUNT_Q       = ~G_LINK_PARITY_IS_ODD;
    localparam logic [6:0] NULL_PATTERN = {1'b1, 1'b1, 1'b1, HUNT_Q, 1'b1, 1'b0, 1'b0};

    typedef enum logic [1:0] {
        ST_HUNT    = 2'd0,
        ST_PAR     = 2'd1,
        ST_FLAG    = 2'd2,
        ST_PAYLOAD = 2'd3
    } state_t;

    state_t         state_r;
    logic [6:0]     hunt_sr_r;
    logic [2:0]     hunt_fill_r;
    logic           par_acc_r;
    logic           par_p_r;
    logic           flag_r;
    logic [3:0]     bit_cnt_r;
    logic [6:0]     data_sr_r;
    logic           esc_pend_r;
    logic [CW-1:0]  disc_cnt_r;

    logic [6:0]     hunt_window_s;
    logic           hunt_match_s;
    logic [1:0]     code_s;

    // Parity over previous payload, P and F must equal the link parity.
    function automatic logic parity_ok(input logic acc, input logic p, input logic f);
        return ((acc ^ p ^ f) == G_LINK_PARITY_IS_ODD);
    endfunction

    // The match is only allowed once 7 bits are already held. This means the
    // first 7 bits after (re)entering hunt can never complete a NULL.
    assign hunt_window_s = {hunt_sr_r[5:0], rx_bit};
    assign hunt_match_s  = (hunt_window_s == NULL_PATTERN) && (hunt_fill_r == 3'd7);
    // {c1,c0}: c0 arrived on the previous payload bit and sits in data_sr_r[6].
    assign code_s        = {rx_bit, data_sr_r[6]};

    // Character framing FSM, parity check, decode and disconnect timer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_HUNT;
            hunt_sr_r   <= 7'd0;
            hunt_fill_r <= 3'd0;
            par_acc_r   <= 1'b0;
            par_p_r     <= 1'b0;
            flag_r      <= 1'b0;
            bit_cnt_r   <= 4'd0;
            data_sr_r   <= 7'd0;
            esc_pend_r  <= 1'b0;
            disc_cnt_r  <= '0;
            tok_valid   <= 1'b0;
            tok_is_ctrl <= 1'b0;
            tok_data    <= 8'd0;
            aligned     <= 1'b0;
            null_seen   <= 1'b0;
            fct_seen    <= 1'b0;
            err_parity  <= 1'b0;
            err_esc     <= 1'b0;
            err_disc    <= 1'b0;
        end else begin
            tok_valid  <= 1'b0;
            null_seen  <= 1'b0;
            fct_seen   <= 1'b0;
            err_parity <= 1'b0;
            err_esc    <= 1'b0;
            err_disc   <= 1'b0;

            if (state_r == ST_HUNT) begin
                disc_cnt_r <= '0;
                if (rx_bit_valid) begin
                    hunt_sr_r <= hunt_window_s;
                    if (hunt_fill_r != 3'd7) begin
                        hunt_fill_r <= hunt_fill_r + 3'd1;
                    end
                    if (hunt_match_s) begin
                        aligned    <= 1'b1;
                        null_seen  <= 1'b1;
                        par_acc_r  <= 1'b0;   // FCC payload parity
                        esc_pend_r <= 1'b0;
                        state_r    <= ST_PAR;
                    end
                end
            end else if (!rx_bit_valid) begin
                if (disc_cnt_r == CW'(G_DISC_TIMEOUT_CLKS - 1)) begin
                    err_disc    <= 1'b1;
                    aligned     <= 1'b0;
                    esc_pend_r  <= 1'b0;
                    disc_cnt_r  <= '0;
                    hunt_sr_r   <= 7'd0;
                    hunt_fill_r <= 3'd0;
                    state_r     <= ST_HUNT;
                end else begin
                    disc_cnt_r <= disc_cnt_r + CW'(1);
                end
            end else begin
                disc_cnt_r <= '0;
                case (state_r)
                    ST_PAR: begin
                        par_p_r <= rx_bit;
                        state_r <= ST_FLAG;
                    end
                    ST_FLAG: begin
                        if (!parity_ok(par_acc_r, par_p_r, rx_bit)) begin
                            err_parity  <= 1'b1;
                            aligned     <= 1'b0;
                            esc_pend_r  <= 1'b0;
                            hunt_sr_r   <= 7'd0;
                            hunt_fill_r <= 3'd0;
                            state_r     <= ST_HUNT;
                        end else begin
                            flag_r    <= rx_bit;
                            bit_cnt_r <= rx_bit ? 4'd2 : 4'd8;
                            par_acc_r <= 1'b0;
                            state_r   <= ST_PAYLOAD;
                        end
                    end
                    ST_PAYLOAD: begin
                        par_acc_r <= par_acc_r ^ rx_bit;
                        data_sr_r <= {rx_bit, data_sr_r[6:1]};
                        bit_cnt_r <= bit_cnt_r - 4'd1;
                        if (bit_cnt_r == 4'd1) begin
                            state_r <= ST_PAR;
                            if (!flag_r) begin
                                if (esc_pend_r) begin
                                    err_esc     <= 1'b1;
                                    aligned     <= 1'b0;
                                    esc_pend_r  <= 1'b0;
                                    hunt_sr_r   <= 7'd0;
                                    hunt_fill_r <= 3'd0;
                                    state_r     <= ST_HUNT;
                                end else begin
                                    tok_valid   <= 1'b1;
                                    tok_is_ctrl <= 1'b0;
                                    tok_data    <= {rx_bit, data_sr_r};
                                end
                            end else begin
                                case (code_s)
                                    2'b00: begin   // FCC
                                        if (esc_pend_r) begin
                                            null_seen  <= 1'b1;
                                            esc_pend_r <= 1'b0;
                                        end else begin
                                            fct_seen <= 1'b1;
                                        end
                                    end
                                    2'b11: begin   // ESC
                                        if (esc_pend_r) begin
                                            err_esc     <= 1'b1;
                                            aligned     <= 1'b0;
                                            esc_pend_r  <= 1'b0;
                                            hunt_sr_r   <= 7'd0;
                                            hunt_fill_r <= 3'd0;
                                            state_r     <= ST_HUNT;
                                        end else begin
                                            esc_pend_r <= 1'b1;
                                        end
                                    end
                                    default: begin // EOP_1 / EOP_2
                                        if (esc_pend_r) begin
                                            err_esc     <= 1'b1;
                                            aligned     <= 1'b0;
                                            esc_pend_r  <= 1'b0;
                                            hunt_sr_r   <= 7'd0;
                                            hunt_fill_r <= 3'd0;
                                            state_r     <= ST_HUNT;
                                        end else begin
                                            tok_valid   <= 1'b1;
                                            tok_is_ctrl <= 1'b1;
                                            tok_data    <= {6'd0, code_s};
                                        end
                                    end
                                endcase
                            end
                        end
                    end
                    default: begin
                        state_r <= ST_HUNT;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ieee1355_rx_char_decoder.sv
// ----------------------------------------------------------------------------
// tb_ieee1355_rx_char_decoder
//
// Directed bench for the IEEE1355 receive character decoder. The stimulus
// pushes the expected event for each character into a queue. The expected
// event holds the output pulse set, the token content, and the cycle it must
// appear in. A negedge monitor pops the queue and compares every pulse the
// DUT raises. A second instance runs with even link parity.
// ----------------------------------------------------------------------------
module tb_ieee1355_rx_char_decoder;

    localparam logic [5:0] F_TOK  = 6'b100000;
    localparam logic [5:0] F_NULL = 6'b010000;
    localparam logic [5:0] F_FCT  = 6'b001000;
    localparam logic [5:0] F_PAR  = 6'b000100;
    localparam logic [5:0] F_ESC  = 6'b000010;
    localparam logic [5:0] F_DISC = 6'b000001;

    typedef struct {
        int         cyc;
        logic [5:0] flags;
        logic       is_ctrl;
        logic [7:0] data;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       rx_bit, rx_bit_valid;
    logic       tok_valid, tok_is_ctrl, aligned, null_seen, fct_seen;
    logic       err_parity, err_esc, err_disc;
    logic [7:0] tok_data;

    logic       rx_bit_e, rx_bit_valid_e;
    logic       tok_valid_e, tok_is_ctrl_e, aligned_e, null_seen_e, fct_seen_e;
    logic       err_parity_e, err_esc_e, err_disc_e;
    logic [7:0] tok_data_e;

    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    int   null_cnt_e = 0;
    exp_t exp_q[$];

    ieee1355_rx_char_decoder #(.G_LINK_PARITY_IS_ODD(1'b1), .G_DISC_TIMEOUT_CLKS(64)) dut (
        .clk(clk), .rst(rst), .rx_bit(rx_bit), .rx_bit_valid(rx_bit_valid),
        .tok_valid(tok_valid), .tok_is_ctrl(tok_is_ctrl), .tok_data(tok_data),
        .aligned(aligned), .null_seen(null_seen), .fct_seen(fct_seen),
        .err_parity(err_parity), .err_esc(err_esc), .err_disc(err_disc)
    );

    ieee1355_rx_char_decoder #(.G_LINK_PARITY_IS_ODD(1'b0), .G_DISC_TIMEOUT_CLKS(64)) dut_even (
        .clk(clk), .rst(rst), .rx_bit(rx_bit_e), .rx_bit_valid(rx_bit_valid_e),
        .tok_valid(tok_valid_e), .tok_is_ctrl(tok_is_ctrl_e), .tok_data(tok_data_e),
        .aligned(aligned_e), .null_seen(null_seen_e), .fct_seen(fct_seen_e),
        .err_parity(err_parity_e), .err_esc(err_esc_e), .err_disc(err_disc_e)
    );

    // Cycle index used to time-stamp expectations.
    always @(posedge clk) cyc <= cyc + 1;

    // Count NULL pulses from the even-parity instance.
    always @(negedge clk) begin
        if (null_seen_e) null_cnt_e = null_cnt_e + 1;
    end

    // Scoreboard monitor: compare every raised pulse against the queue head.
    always @(negedge clk) begin
        logic [5:0] flags;
        exp_t e;
        if (!rst) begin
            flags = {tok_valid, null_seen, fct_seen, err_parity, err_esc, err_disc};
            if (flags != 6'd0) begin
                tests = tests + 1;
                if (exp_q.size() == 0) begin
                    fails = fails + 1;
                    $display("FAIL unexpected_event: got flags=%b data=%h at cyc %0d, expected none",
                             flags, tok_data, cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (flags != e.flags || cyc != e.cyc ||
                        (e.flags[5] && ({tok_is_ctrl, tok_data} != {e.is_ctrl, e.data}))) begin
                        fails = fails + 1;
                        $display("FAIL event: got flags=%b ctrl=%b data=%h cyc=%0d, expected flags=%b ctrl=%b data=%h cyc=%0d",
                                 flags, tok_is_ctrl, tok_data, cyc, e.flags, e.is_ctrl, e.data, e.cyc);
                    end
                end
            end else if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                tests = tests + 1;
                fails = fails + 1;
                e = exp_q.pop_front();
                $display("FAIL missing_event: got nothing by cyc %0d, expected flags=%b at cyc %0d",
                         cyc, e.flags, e.cyc);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests = tests + 1;
        if (act !== exp) begin
            fails = fails + 1;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk);
        rx_bit       = b;
        rx_bit_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_bit_valid = 1'b0;
    endtask

    // bits[n-1] goes on the wire first.
    task automatic send_bits(input logic [15:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) send_bit(bits[i]);
    endtask

    task automatic send_bit_e(input logic b);
        @(negedge clk);
        rx_bit_e       = b;
        rx_bit_valid_e = 1'b1;
        @(posedge clk);
        #1;
        rx_bit_valid_e = 1'b0;
    endtask

    task automatic send_bits_e(input logic [15:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) send_bit_e(bits[i]);
    endtask

    task automatic expect_at(input int c, input logic [5:0] f, input logic ctl, input logic [7:0] d);
        exp_t e;
        e.cyc = c; e.flags = f; e.is_ctrl = ctl; e.data = d;
        exp_q.push_back(e);
    endtask

    // Expect an event in the cycle right after the bit just sent.
    task automatic expect_now(input logic [5:0] f, input logic ctl, input logic [7:0] d);
        expect_at(cyc, f, ctl, d);
    endtask

    initial begin
        rst = 1'b1; rx_bit = 1'b0; rx_bit_valid = 1'b0;
        rx_bit_e = 1'b0; rx_bit_valid_e = 1'b0;
        idle(3);
        check("reset_outputs",
              {19'd0, tok_valid, tok_is_ctrl, tok_data, aligned, null_seen, fct_seen,
               err_parity, err_esc, err_disc}, 32'd0);
        @(negedge clk); rst = 1'b0;

        // Align, data A5, EOP_1, standalone FCC.
        send_bits(16'b01110100, 8);      expect_now(F_NULL, 1'b0, 8'h00);
        check("aligned_after_null", {31'd0, aligned}, 32'd1);
        send_bits(16'b1010100101, 10);   expect_now(F_TOK, 1'b0, 8'hA5);
        send_bits(16'b0101, 4);          expect_now(F_TOK, 1'b1, 8'h02);
        send_bits(16'b1100, 4);          expect_now(F_FCT, 1'b0, 8'h00);
        // ESC then EOP_2 -> escape error, back to hunt.
        send_bits(16'b0111, 4);
        send_bits(16'b0110, 4);          expect_now(F_ESC, 1'b0, 8'h00);
        idle(1);
        check("aligned_after_err_esc", {31'd0, aligned}, 32'd0);

        // Realign, data, then EOP_1 with P flipped -> parity error on F bit.
        send_bits(16'b01110100, 8);      expect_now(F_NULL, 1'b0, 8'h00);
        send_bits(16'b1010100101, 10);   expect_now(F_TOK, 1'b0, 8'hA5);
        send_bits(16'b11, 2);            expect_now(F_PAR, 1'b0, 8'h00);
        send_bits(16'b01, 2);
        check("aligned_after_err_parity", {31'd0, aligned}, 32'd0);

        // 63 idle clocks survive; 64 idle clocks disconnect.
        send_bits(16'b01110100, 8);      expect_now(F_NULL, 1'b0, 8'h00);
        send_bits(16'b1010100101, 10);   expect_now(F_TOK, 1'b0, 8'hA5);
        idle(63);
        check("aligned_after_63_idle", {31'd0, aligned}, 32'd1);
        send_bits(16'b0100, 4);          expect_now(F_FCT, 1'b0, 8'h00);
        expect_at(cyc + 64, F_DISC, 1'b0, 8'h00);
        idle(64);
        check("aligned_after_disc", {31'd0, aligned}, 32'd0);

        // Reset in the middle of a data character, then realign.
        send_bits(16'b01110100, 8);      expect_now(F_NULL, 1'b0, 8'h00);
        send_bits(16'b0101, 4);          expect_now(F_TOK, 1'b1, 8'h02);
        send_bits(16'b00101, 5);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        check("mid_char_reset_outputs",
              {19'd0, tok_valid, tok_is_ctrl, tok_data, aligned, null_seen, fct_seen,
               err_parity, err_esc, err_disc}, 32'd0);
        @(negedge clk); rst = 1'b0;
        send_bits(16'b01110100, 8);      expect_now(F_NULL, 1'b0, 8'h00);
        check("aligned_after_realign", {31'd0, aligned}, 32'd1);
        // In-stream NULL: ESC followed by FCC.
        send_bits(16'b0111, 4);
        send_bits(16'b0100, 4);          expect_now(F_NULL, 1'b0, 8'h00);

        // Even link: odd-link NULL ignored, even-link NULL accepted.
        send_bits_e(16'b01110100, 8);
        idle(1);
        check("even_ignores_odd_null", null_cnt_e, 32'd0);
        check("even_not_aligned", {31'd0, aligned_e}, 32'd0);
        send_bits_e(16'b11111100, 8);
        idle(1);
        check("even_null_seen", null_cnt_e, 32'd1);
        check("even_aligned", {31'd0, aligned_e}, 32'd1);

        idle(5);
        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
